// File: rtl/bsg_chip_pkg.sv
// Shared bsg_tag transmitter types and sizes.
// Frame: start, len, data_not_reset, id, payload (LSB first).
package bsg_chip_pkg;

  localparam int tag_els_gp               = 1024;
  localparam int tag_lg_els_gp            = 10;
  localparam int tag_max_payload_width_gp = 12;
  localparam int tag_lg_width_gp          = 4;

  localparam int tag_tx_hdr_width_gp =
    1 + tag_lg_width_gp + 1 + tag_lg_els_gp;

  localparam int tag_tx_frame_width_gp =
    tag_tx_hdr_width_gp + tag_max_payload_width_gp;

  localparam int tag_tx_cnt_width_gp =
    $clog2(tag_tx_frame_width_gp + 1);

  typedef struct packed {
    logic [tag_max_payload_width_gp-1:0] payload;
    logic [tag_lg_els_gp-1:0]            id;
    logic                                data_not_reset;
    logic [tag_lg_width_gp-1:0]          len;
  } bsg_chip_tag_tx_pkt_s;

  typedef enum logic [1:0] {
    e_idle,
    e_hdr,
    e_pay,
    e_gap
  } tag_tx_state_e;

  // Bits at or above len are zeroed so the tail of the frame idles at 0.
  function automatic logic [tag_max_payload_width_gp-1:0]
    tag_payload_mask(
      input logic [tag_max_payload_width_gp-1:0] payload,
      input logic [tag_lg_width_gp-1:0]          len
    );
    logic [tag_max_payload_width_gp-1:0] m;
    m = '0;
    for (int i = 0; i < tag_max_payload_width_gp; i++) begin
      m[i] = payload[i] & (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/bsg_chip_tag_tx_piso.sv
// Loadable parallel-in/serial-out shift register, LSB out first.
// Zeros shift in from the top so an exhausted register idles at 0.
module bsg_chip_tag_tx_piso
  import bsg_chip_pkg::*;
#(
  parameter int width_p = tag_tx_frame_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [width_p-1:0] data_i,
  output logic               data_o
);

  logic [width_p-1:0] sr_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {1'b0, sr_q[width_p-1:1]};
    end
  end

  assign data_o = sr_q[0];

endmodule

// File: rtl/bsg_chip_tag_tx.sv
// bsg_tag serial transmitter: one request in flight, registered output.
// Define BSG_TAG_TX_GAP_EN to insert gap_p idle cycles after each frame.
module bsg_chip_tag_tx
  import bsg_chip_pkg::*;
#(
  parameter int els_p               = tag_els_gp,
  parameter int lg_els_p            = tag_lg_els_gp,
  parameter int max_payload_width_p = tag_max_payload_width_gp,
  parameter int lg_width_p          = tag_lg_width_gp,
  parameter int gap_p               = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic [lg_els_p-1:0]            id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_p-1:0]          len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_data_o,
  output logic                           busy_o,
  output logic                           err_o
);

  typedef logic [tag_tx_cnt_width_gp-1:0] cnt_t;

  // Holds ready low if the id space cannot address every client.
  localparam bit cfg_ok_lp =
    (els_p <= (1 << lg_els_p)) && (gap_p > 0);

  localparam logic [lg_width_p:0] max_len_lp =
    max_payload_width_p[lg_width_p:0];

  localparam cnt_t hdr_last_lp =
    cnt_t'(tag_tx_hdr_width_gp - 1);

  localparam cnt_t gap_last_lp = cnt_t'(gap_p - 1);

`ifdef BSG_TAG_TX_GAP_EN
  localparam tag_tx_state_e done_lp = e_gap;
`else
  localparam tag_tx_state_e done_lp = e_idle;
`endif

  tag_tx_state_e state_q, state_n;
  cnt_t          cnt_q, cnt_n;
  logic [lg_width_p-1:0] len_q;
  logic          live_q;
  logic          err_q;

  logic accept;
  logic too_long;
  logic load;
  logic shift;
  cnt_t pay_last;

  bsg_chip_tag_tx_pkt_s pkt;
  logic [tag_tx_frame_width_gp-1:0] frame;

  assign ready_and_o = cfg_ok_lp & live_q
                     & (state_q == e_idle);
  assign accept   = v_i & ready_and_o;
  assign too_long = {1'b0, len_i} > max_len_lp;
  assign load     = accept & ~too_long;
  assign pay_last = cnt_t'(len_q) - cnt_t'(1);

  always_comb begin
    pkt = '0;
    pkt.payload = tag_payload_mask(payload_i, len_i);
    pkt.id             = id_i;
    pkt.data_not_reset = data_not_reset_i;
    pkt.len            = len_i;
  end

  assign frame = {pkt, 1'b1};

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    shift   = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (load) begin
          state_n = e_hdr;
          cnt_n   = '0;
        end
      end
      e_hdr: begin
        shift = 1'b1;
        if (cnt_q == hdr_last_lp) begin
          cnt_n   = '0;
          state_n = (len_q != '0) ? e_pay : done_lp;
        end else begin
          cnt_n = cnt_q + cnt_t'(1);
        end
      end
      e_pay: begin
        shift = 1'b1;
        if (cnt_q == pay_last) begin
          cnt_n   = '0;
          state_n = done_lp;
        end else begin
          cnt_n = cnt_q + cnt_t'(1);
        end
      end
      e_gap: begin
        if (cnt_q == gap_last_lp) begin
          cnt_n   = '0;
          state_n = e_idle;
        end else begin
          cnt_n = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_n = e_idle;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      len_q   <= '0;
      live_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      live_q  <= 1'b1;
      err_q   <= accept & too_long;
      if (load) begin
        len_q <= len_i;
      end
    end
  end

  bsg_chip_tag_tx_piso #(
    .width_p(tag_tx_frame_width_gp)
  ) piso (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (load),
    .shift_i  (shift),
    .data_i   (frame),
    .data_o   (tag_data_o)
  );

  assign busy_o = (state_q != e_idle);
  assign err_o  = err_q;

endmodule

// File: tb/tb_bsg_chip_tag_tx.sv
// Scoreboard bench for bsg_chip_tag_tx: expected frames are
// hand-written bit strings in transmission order.
module tb_bsg_chip_tag_tx;

  logic        clk;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_and_o;
  logic [9:0]  id_i;
  logic        data_not_reset_i;
  logic [3:0]  len_i;
  logic [11:0] payload_i;
  logic        tag_data_o;
  logic        busy_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  string exp_q[$];
  bit    in_frame = 0;
  int    zeros    = 0;
  int    last_gap = -1;

  bsg_chip_tag_tx dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .v_i             (v_i),
    .ready_and_o     (ready_and_o),
    .id_i            (id_i),
    .data_not_reset_i(data_not_reset_i),
    .len_i           (len_i),
    .payload_i       (payload_i),
    .tag_data_o      (tag_data_o),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  // Monitor: detects start bits, collects frames, compares.
  initial begin : monitor
    string exp;
    string got;
    bit    busy_ok;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        in_frame = 0;
        zeros    = 0;
      end else if (!in_frame) begin
        if (tag_data_o === 1'b1) begin
          last_gap = zeros;
          zeros    = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame got=start want=idle");
          end else begin
            exp      = exp_q.pop_front();
            got      = "1";
            busy_ok  = (busy_o === 1'b1);
            in_frame = 1;
          end
        end else begin
          zeros++;
        end
      end else begin
        got = {got, (tag_data_o === 1'b1) ? "1" : "0"};
        busy_ok &= (busy_o === 1'b1);
      end
      if (in_frame && got.len() == exp.len()) begin
        in_frame = 0;
        checks++;
        if (got != exp || !busy_ok) begin
          failures++;
          $display("FAIL frame got=%s busy_ok=%0d want=%s",
                   got, busy_ok, exp);
        end
      end
    end
  end

  task automatic send(input logic [9:0]  id,
                      input logic        dnr,
                      input logic [3:0]  len,
                      input logic [11:0] pl,
                      input string       exp,
                      input bit          hold);
    int n = 0;
    @(negedge clk);
    v_i = 1; id_i = id; data_not_reset_i = dnr;
    len_i = len; payload_i = pl;
    while (!ready_and_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_and_o) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=0 want=1");
      v_i = 0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (!hold) v_i = 0;
  endtask

  localparam string F1 = {"1", "1100", "1", "1010000000", "101"};
  localparam string F2 = {"1", "0000", "0", "1111111111"};
  localparam string F3 =
    {"1", "0011", "1", "0101010000", "001110100101"};
  localparam string F6A = {"1", "1000", "1", "1000000000", "1"};
  localparam string F6B = {"1", "0100", "0", "0100000000", "01"};

  initial begin : main
    int exp_gap;
    int n;
`ifdef BSG_TAG_TX_GAP_EN
    exp_gap = 5;
`else
    exp_gap = 1;
`endif
    reset_n_i = 0; v_i = 0; id_i = 0;
    data_not_reset_i = 0; len_i = 0; payload_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tag", tag_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", ready_and_o, 0);
    @(negedge clk) reset_n_i = 1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", ready_and_o, 1);

    // Basic frame, then same frame with junk above len.
    send(10'd5, 1'b1, 4'd3, 12'h005, F1, 0);
    send(10'd5, 1'b1, 4'd3, 12'hFFD, F1, 0);
    // Header-only reset packet.
    send(10'h3FF, 1'b0, 4'd0, 12'hFFF, F2, 0);
    // Full-length payload.
    send(10'h2A, 1'b1, 4'd12, 12'hA5C, F3, 0);

    // Over-length request is swallowed with an error pulse.
    n = 0;
    @(negedge clk);
    while (!ready_and_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    v_i = 1; id_i = 10'd7; len_i = 4'd13; payload_i = 12'hFFF;
    chk("err_ready", ready_and_o, 1);
    @(posedge clk);
    #1;
    v_i = 0;
    chk("err_pulse", err_o, 1);
    chk("err_busy", busy_o, 0);
    chk("err_tag", tag_data_o, 0);
    @(posedge clk);
    #1;
    chk("err_clear", err_o, 0);
    chk("err_ready_after", ready_and_o, 1);

    // Reset in the middle of the payload.
    send(10'h2A, 1'b1, 4'd12, 12'hA5C, F3, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("bit20_before_rst", tag_data_o, 1);
    reset_n_i = 0;
    #1;
    chk("mid_rst_tag", tag_data_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    @(negedge clk) reset_n_i = 1;
    send(10'h2A, 1'b1, 4'd12, 12'hA5C, F3, 0);

    // Back-to-back requests with v_i held high.
    send(10'd1, 1'b1, 4'd1, 12'h001, F6A, 1);
    send(10'd2, 1'b0, 4'd2, 12'h002, F6B, 0);

    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_gap", last_gap, exp_gap);
    chk("idle_tag", tag_data_o, 0);
    chk("idle_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
